// File: rtl/uart_sched_pkg.sv
// Shared types and constants for the UART TX round-robin scheduler.
// The header byte carries the granted channel ID in its low nibble.
package uart_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    DATA = 2'd2
  } state_e;

  localparam int         ID_W     = 4;
  localparam logic [7:0] HDR_BASE = 8'hA0;

  function automatic logic [7:0] hdr_byte(input logic [ID_W-1:0] id);
    return HDR_BASE | 8'(id);
  endfunction

endpackage

// File: rtl/uart_tx_scheduler_if.sv
// Bundle of per-requester byte ports and the shared serializer byte port.
// slave = scheduler side, master = producers plus serializer side.
interface uart_tx_scheduler_if #(
  parameter int NUM_REQ = 4
);
  import uart_sched_pkg::*;

  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_last;
  logic [NUM_REQ-1:0]   req_ready;
  logic                 tx_valid;
  logic [7:0]           tx_data;
  logic                 tx_ready;
  logic [ID_W-1:0]      grant_id;
  logic                 busy;

  modport master (
    output req_valid, req_data, req_last, tx_ready,
    input  req_ready, tx_valid, tx_data, grant_id, busy
  );

  modport slave (
    input  req_valid, req_data, req_last, tx_ready,
    output req_ready, tx_valid, tx_data, grant_id, busy
  );

endinterface

// File: rtl/uart_tx_scheduler_rr_arbiter.sv
// Combinational rotating-priority picker: first set request searching
// upward from last_id+1 with wrap.
module rr_arbiter
  import uart_sched_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [ID_W-1:0]    last_id_i,
  output logic [ID_W-1:0]    gnt_id_o,
  output logic               any_req_o
);
  localparam int PW = ID_W + 1;

  logic [PW-1:0]        start_s;
  logic [2*NUM_REQ-1:0] dbl_s;
  logic [2*NUM_REQ-1:0] shift_s;
  logic [NUM_REQ-1:0]   rot_s;
  logic [PW-1:0]        pos_s;
  logic [PW-1:0]        sum_s;
  logic [PW-1:0]        wrap_s;

  // Rotating the doubled vector puts the highest-priority request at bit 0;
  // start_s == NUM_REQ simply selects the upper copy, which is the wrap.
  assign start_s = {1'b0, last_id_i} + {{ID_W{1'b0}}, 1'b1};
  assign dbl_s   = {req_i, req_i};
  assign shift_s = dbl_s >> start_s;
  assign rot_s   = shift_s[NUM_REQ-1:0];

  // Lowest set bit of the rotated vector wins
  always_comb begin
    pos_s     = {PW{1'b0}};
    any_req_o = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      pos_s     = rot_s[k] ? PW'(k) : pos_s;
      any_req_o = any_req_o | rot_s[k];
    end
  end

  assign sum_s    = start_s + pos_s;
  assign wrap_s   = (sum_s >= PW'(NUM_REQ)) ? (sum_s - PW'(NUM_REQ)) : sum_s;
  assign gnt_id_o = wrap_s[ID_W-1:0];

endmodule

// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler sharing one UART TX byte port among NUM_REQ producers,
// granting bursts of up to MAX_BURST bytes, optionally led by a channel-ID header.
module uart_tx_scheduler
  import uart_sched_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int MAX_BURST = 4,
  parameter bit HDR_EN    = 1'b1
) (
  input logic                clk,
  input logic                rst,
  uart_tx_scheduler_if.slave bus
);
  state_e             state_q;
  logic [ID_W-1:0]    grant_q;
  logic [ID_W-1:0]    last_id_q;
  logic [7:0]         beat_cnt_q;
  logic [7:0]         beat_cnt_d;
  logic               busy_q;

  logic [ID_W-1:0]    arb_id_s;
  logic               any_req_s;
  logic               g_valid_s;
  logic               g_last_s;
  logic [7:0]         g_data_s;
  logic               tx_valid_s;
  logic [7:0]         tx_data_s;
  logic [NUM_REQ-1:0] req_ready_s;
  logic               hs_s;
  logic               burst_end_s;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req_i     (bus.req_valid),
    .last_id_i (last_id_q),
    .gnt_id_o  (arb_id_s),
    .any_req_o (any_req_s)
  );

  // Select the granted requester's byte lane
  always_comb begin
    g_valid_s = 1'b0;
    g_last_s  = 1'b0;
    g_data_s  = 8'h00;
    for (int i = 0; i < NUM_REQ; i++) begin
      g_valid_s = g_valid_s | (bus.req_valid[i] & (grant_q == ID_W'(i)));
      g_last_s  = g_last_s  | (bus.req_last[i]  & (grant_q == ID_W'(i)));
      g_data_s  = g_data_s  | (bus.req_data[8*i +: 8] & {8{grant_q == ID_W'(i)}});
    end
  end

  // Steer the serializer port; DATA is a zero-latency pass-through
  always_comb begin
    tx_valid_s  = 1'b0;
    tx_data_s   = 8'h00;
    req_ready_s = {NUM_REQ{1'b0}};
    case (state_q)
      IDLE: begin
        tx_valid_s = 1'b0;
        tx_data_s  = 8'h00;
      end
      HDR: begin
        tx_valid_s = 1'b1;
        tx_data_s  = hdr_byte(grant_q);
      end
      DATA: begin
        tx_valid_s = g_valid_s;
        tx_data_s  = g_data_s;
        for (int i = 0; i < NUM_REQ; i++) begin
          req_ready_s[i] = bus.tx_ready & (grant_q == ID_W'(i));
        end
      end
      default: begin
        tx_valid_s = 1'b0;
        tx_data_s  = 8'h00;
      end
    endcase
  end

  assign hs_s        = (state_q == DATA) && tx_valid_s && bus.tx_ready;
  assign burst_end_s = g_last_s || (beat_cnt_q == 8'(MAX_BURST - 1));
  assign beat_cnt_d  = beat_cnt_q + 8'd1;

  // Scheduler FSM: arbitrate in IDLE, optional header, then the data burst
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      grant_q    <= {ID_W{1'b0}};
      last_id_q  <= ID_W'(NUM_REQ - 1);
      beat_cnt_q <= 8'd0;
      busy_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (any_req_s) begin
            grant_q    <= arb_id_s;
            beat_cnt_q <= 8'd0;
            busy_q     <= 1'b1;
            state_q    <= HDR_EN ? HDR : DATA;
          end
        end
        HDR: begin
          if (bus.tx_ready) begin
            state_q <= DATA;
          end
        end
        DATA: begin
          if (hs_s) begin
            beat_cnt_q <= beat_cnt_d;
            if (burst_end_s) begin
              last_id_q <= grant_q;
              grant_q   <= {ID_W{1'b0}};
              busy_q    <= 1'b0;
              state_q   <= IDLE;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          grant_q <= {ID_W{1'b0}};
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.tx_valid  = tx_valid_s;
  assign bus.tx_data   = tx_data_s;
  assign bus.req_ready = req_ready_s;
  assign bus.grant_id  = grant_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Scoreboard bench: a transaction-level round-robin model predicts the byte
// stream; a monitor checks every accepted byte and the per-cycle port rules.
module tb_uart_tx_scheduler;
  import uart_sched_pkg::*;

  localparam int N  = 4;
  localparam int MB = 4;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_tx_scheduler_if #(.NUM_REQ(N)) bus_a ();
  uart_tx_scheduler_if #(.NUM_REQ(N)) bus_b ();

  uart_tx_scheduler #(.NUM_REQ(N), .MAX_BURST(MB), .HDR_EN(1'b1)) dut_a (
    .clk (clk), .rst (rst), .bus (bus_a)
  );
  uart_tx_scheduler #(.NUM_REQ(N), .MAX_BURST(MB), .HDR_EN(1'b0)) dut_b (
    .clk (clk), .rst (rst), .bus (bus_b)
  );

  beat_t      src_q [N][$];
  logic [7:0] exp_q [$];
  int         model_last = N - 1;
  int         errors = 0;
  int         checks = 0;
  bit         drv_en = 1'b0;
  int         ready_pct = 100;
  int         gap_pct = 0;
  int         force_stall = 0;
  int         stall_after = -1;
  int         tx_hs = 0;
  int         rr_hs [N];
  logic [7:0] prev_data = 8'h00;
  bit         prev_stall = 1'b0;
  logic [N-1:0] allowed;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_beat(input int id, input logic [7:0] d, input logic l);
    beat_t x;
    x.data = d;
    x.last = l;
    src_q[id].push_back(x);
  endtask

  task automatic add_msg(input int id, input int len, input logic [7:0] base);
    for (int b = 0; b < len; b++) push_beat(id, base + 8'(b), (b == len - 1));
  endtask

  function automatic int pending();
    int s = 0;
    for (int i = 0; i < N; i++) s += src_q[i].size();
    return s;
  endfunction

  // Reference: serve the loaded messages in round-robin burst order
  task automatic model_push();
    beat_t mq [N][$];
    int    id;
    int    sent;
    bit    more = 1'b1;
    for (int i = 0; i < N; i++) mq[i] = src_q[i];
    while (more) begin
      id = -1;
      for (int k = 1; k <= N; k++) begin
        if (id < 0 && mq[(model_last + k) % N].size() > 0) id = (model_last + k) % N;
      end
      if (id < 0) begin
        more = 1'b0;
      end else begin
        exp_q.push_back(8'hA0 | 8'(id));
        sent = 0;
        while (sent < MB && mq[id].size() > 0) begin
          beat_t b;
          b = mq[id].pop_front();
          exp_q.push_back(b.data);
          sent++;
          if (b.last) sent = MB;
        end
        model_last = id;
      end
    end
  endtask

  task automatic drain(input string name);
    int cyc = 0;
    while ((exp_q.size() != 0 || pending() != 0) && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (cyc >= 3000) begin
      errors++;
      $display("FAIL %s_timeout: %0d bytes outstanding, expected 0", name, exp_q.size());
    end
    repeat (3) @(negedge clk);
    #4;
    chk({name, "_busy_after"}, 32'(bus_a.busy), 32'd0);
    chk({name, "_txv_after"}, 32'(bus_a.tx_valid), 32'd0);
  endtask

  // Producers and serializer for dut_a: present queue heads, pop on accept
  always begin
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      bit gap;
      gap = bus_a.busy && (bus_a.grant_id == 4'(i)) && ($urandom_range(0, 99) < gap_pct);
      bus_a.req_valid[i]       = drv_en && (src_q[i].size() > 0) && !gap;
      bus_a.req_data[8*i +: 8] = (src_q[i].size() > 0) ? src_q[i][0].data : 8'h00;
      bus_a.req_last[i]        = (src_q[i].size() > 0) ? src_q[i][0].last : 1'b0;
    end
    bus_a.tx_ready = drv_en && (force_stall == 0) && ($urandom_range(0, 99) < ready_pct);
    if (force_stall > 0) force_stall--;
    #2;
    if (drv_en && !rst) begin
      for (int i = 0; i < N; i++) begin
        if (bus_a.req_valid[i] && bus_a.req_ready[i]) begin
          void'(src_q[i].pop_front());
          rr_hs[i]++;
        end
      end
      if (bus_a.tx_valid && bus_a.tx_ready) begin
        tx_hs++;
        if (tx_hs == stall_after) force_stall = 10;
      end
    end
  end

  // Monitor: compare accepted bytes against the model and check port rules
  always begin
    @(negedge clk);
    #3;
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      allowed = bus_a.busy ? (4'b0001 << bus_a.grant_id) : 4'b0000;
      chk("ready_only_granted", 32'(bus_a.req_ready & ~allowed), 32'd0);
      if (!bus_a.tx_ready) chk("ready_during_stall", 32'(bus_a.req_ready), 32'd0);
      if (prev_stall && bus_a.tx_valid) chk("stall_data_stable", 32'(bus_a.tx_data), 32'(prev_data));
      if (bus_a.tx_valid && bus_a.tx_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL tx_extra: got byte 0x%0h, expected no byte", bus_a.tx_data);
        end else begin
          chk("tx_byte", 32'(bus_a.tx_data), 32'(exp_q.pop_front()));
        end
      end
      prev_stall = bus_a.tx_valid && !bus_a.tx_ready;
      prev_data  = bus_a.tx_data;
    end
  end

  initial begin
    int hs0;
    int cyc;
    for (int i = 0; i < N; i++) rr_hs[i] = 0;
    bus_b.req_valid = 4'b0000;
    bus_b.req_data  = 32'h0;
    bus_b.req_last  = 4'b0000;
    bus_b.tx_ready  = 1'b0;

    repeat (3) @(negedge clk);
    #1;
    chk("rst_tx_valid", 32'(bus_a.tx_valid), 32'd0);
    chk("rst_tx_data", 32'(bus_a.tx_data), 32'd0);
    chk("rst_req_ready", 32'(bus_a.req_ready), 32'd0);
    chk("rst_grant_id", 32'(bus_a.grant_id), 32'd0);
    chk("rst_busy", 32'(bus_a.busy), 32'd0);
    @(negedge clk);
    rst    = 1'b0;
    drv_en = 1'b1;

    // Round robin: 1-byte messages from everyone, requester 0 twice
    add_msg(0, 1, 8'h10); add_msg(1, 1, 8'h21); add_msg(2, 1, 8'h32);
    add_msg(3, 1, 8'h43); add_msg(0, 1, 8'h14);
    model_push();
    drain("round_robin");

    // Burst limit: requester 1 streams 6 bytes while requester 0 waits
    add_msg(1, 6, 8'h30);
    add_msg(0, 2, 8'h50);
    model_push();
    drain("burst_limit");

    // Single requester with arbitration-latency check
    rr_hs[2] = 0;
    push_beat(2, 8'h11, 1'b0);
    push_beat(2, 8'h22, 1'b1);
    model_push();
    @(negedge clk);
    @(negedge clk);
    #4;
    chk("arb_latency_busy", 32'(bus_a.busy), 32'd1);
    chk("arb_latency_grant", 32'(bus_a.grant_id), 32'd2);
    chk("arb_latency_hdr", 32'(bus_a.tx_data), 32'hA2);
    drain("single");
    chk("req2_accepts", 32'(rr_hs[2]), 32'd2);

    // Backpressure: stall in HDR, then again in DATA after two data bytes
    force_stall = 12;
    stall_after = tx_hs + 3;
    add_msg(3, 6, 8'h70);
    model_push();
    drain("backpressure");
    stall_after = -1;

    // Randomized traffic with serializer stalls and producer gaps
    for (int r = 0; r < 6; r++) begin
      ready_pct = $urandom_range(30, 90);
      gap_pct   = 20;
      for (int i = 0; i < N; i++) begin
        int nm;
        nm = $urandom_range(0, 2);
        for (int m = 0; m < nm; m++) add_msg(i, $urandom_range(1, 7), 8'($urandom_range(0, 255)));
      end
      model_push();
      drain("random");
    end
    ready_pct = 100;
    gap_pct   = 0;

    // Reset mid-burst after the second data byte
    add_msg(2, 4, 8'h90);
    model_push();
    hs0 = tx_hs;
    cyc = 0;
    while (tx_hs < hs0 + 3 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (cyc >= 100) begin
      errors++;
      $display("FAIL reset_wait_timeout: %0d handshakes seen, expected 3", tx_hs - hs0);
    end
    #1;
    rst = 1'b1;
    #1;
    chk("midrst_tx_valid", 32'(bus_a.tx_valid), 32'd0);
    chk("midrst_grant_id", 32'(bus_a.grant_id), 32'd0);
    chk("midrst_busy", 32'(bus_a.busy), 32'd0);
    for (int i = 0; i < N; i++) src_q[i].delete();
    exp_q.delete();
    model_last = N - 1;
    @(negedge clk);
    rst = 1'b0;
    add_msg(2, 1, 8'hC2);
    add_msg(0, 1, 8'hC0);
    model_push();
    drain("after_reset");

    // No-header instance: req 3 then req 0/3 contention
    @(negedge clk);
    bus_b.req_valid = 4'b1000;
    bus_b.req_data  = {8'h5A, 24'h000000};
    bus_b.req_last  = 4'b1000;
    bus_b.tx_ready  = 1'b1;
    #1;
    chk("nohdr_idle_first", 32'(bus_b.tx_valid), 32'd0);
    @(negedge clk);
    #1;
    chk("nohdr_tx_valid", 32'(bus_b.tx_valid), 32'd1);
    chk("nohdr_tx_data", 32'(bus_b.tx_data), 32'h5A);
    chk("nohdr_grant", 32'(bus_b.grant_id), 32'd3);
    chk("nohdr_req_ready", 32'(bus_b.req_ready), 32'h8);
    @(negedge clk);
    bus_b.req_valid = 4'b1001;
    bus_b.req_data  = {8'h5B, 16'h0000, 8'h66};
    bus_b.req_last  = 4'b1001;
    #1;
    chk("nohdr_turnaround_busy", 32'(bus_b.busy), 32'd0);
    @(negedge clk);
    #1;
    chk("nohdr_rr_grant", 32'(bus_b.grant_id), 32'd0);
    chk("nohdr_rr_data", 32'(bus_b.tx_data), 32'h66);
    @(negedge clk);
    bus_b.req_valid = 4'b1000;
    @(negedge clk);
    #1;
    chk("nohdr_next_grant", 32'(bus_b.grant_id), 32'd3);
    chk("nohdr_next_data", 32'(bus_b.tx_data), 32'h5B);
    @(negedge clk);
    bus_b.req_valid = 4'b0000;
    bus_b.tx_ready  = 1'b0;
    repeat (2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_scheduler.md
# uart_tx_scheduler

Round-robin scheduler that shares one UART transmitter byte interface among NUM_REQ requesters. It grants the transmitter to one requester at a time for a burst of up to MAX_BURST bytes, optionally prefixed by a channel-ID header byte, then rotates. It sits between the per-channel byte producers and the UART TX serializer's valid/ready byte port.

## Interface
- NUM_REQ, 4: number of requesters, 2..16
- MAX_BURST, 4: maximum data bytes per grant, 1..255
- HDR_EN, 1: 1 = emit header byte 0xA0 | id before each burst; 0 = no header
- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-high
- req_valid  input  NUM_REQ  per-requester byte valid
- req_data  input  8*NUM_REQ  per-requester byte; requester i uses bits [8i+7:8i]
- req_last  input  NUM_REQ  marks the final byte of the requester's message
- req_ready  output  NUM_REQ  per-requester accept; only the granted bit can be 1
- tx_valid  output  1  byte valid to the UART serializer
- tx_data  output  8  byte to the serializer
- tx_ready  input  1  serializer accepts the byte
- grant_id  output  4  current grant index; 0 when idle
- busy  output  1  1 in HDR or DATA state

## Operation
- States: IDLE, HDR, DATA.
- IDLE: if any req_valid is set, select the first set bit searching upward (with wrap) from last_id+1. Register the result into grant_id, clear beat_cnt, then go to HDR if HDR_EN, else to DATA. With no req_valid set, stay in IDLE.
- HDR: tx_valid=1, tx_data = 0xA0 | grant_id, req_ready=0. On tx_ready, go to DATA.
- DATA: combinational pass-through for the granted requester g:
  - tx_valid = req_valid[g]
  - tx_data = req_data[g]
  - req_ready[g] = tx_ready
  - all other req_ready bits are 0
- A handshake is tx_valid && tx_ready. On each handshake, beat_cnt increments.
- The burst ends on a handshake with req_last[g]=1, or on a handshake where beat_cnt == MAX_BURST-1. At burst end: last_id <= g, go to IDLE.
- If req_valid[g] drops mid-burst, the grant is held and no timeout applies. The requester owns stalls.
- Requesters not granted see req_ready=0 and must hold their data (valid/ready rules).
- beat_cnt is 8 bits and never wraps, because the burst ends at MAX_BURST-1.
- In IDLE: tx_valid=0, tx_data=0, req_ready=0.

## Timing
- Reset values:
  - state=IDLE, last_id=NUM_REQ-1 (requester 0 has first priority)
  - grant_id=0, beat_cnt=0, busy=0
  - tx_valid=0, tx_data=0, req_ready=0
- Reset mid-burst returns immediately to IDLE. The partial message is abandoned; the serializer sees tx_valid fall asynchronously.
- Arbitration latency: req_valid seen in IDLE at cycle N, so HDR or DATA is active at N+1.
- Turnaround: a burst ending at cycle N gives IDLE at N+1 and the next grant at N+2, so there is one idle cycle between bursts.
- DATA-phase data path latency is zero; req_ready is combinational from tx_ready.
- Requests arriving during a burst are only considered at the next IDLE. No preemption.
- If req_last arrives on the same beat as the MAX_BURST limit, the burst ends once (the same transition).

## Structure
- Shared package uart_sched_pkg:
  - state enum (IDLE, HDR, DATA)
  - HDR_BASE = 8'hA0
  - ID_W = 4
- Sub-module rr_arbiter: combinational rotating-priority picker.
  - Inputs: req vector and last_id.
  - Outputs: gnt_id and any_req.
  - Instantiated once.

## Test plan
- Single requester: HDR_EN=1, req 2 sends 0x11, 0x22 (last). Expected: tx sequence 0xA2, 0x11, 0x22; req_ready[2] pulses twice; back to IDLE, busy=0.
- Round robin: all 4 requesters hold valid with 1-byte messages. Expected grant order 0, 1, 2, 3, 0; headers 0xA0, 0xA1, 0xA2, 0xA3, 0xA0.
- Burst limit: MAX_BURST=4, req 1 streams 6 bytes with no last, req 0 also valid. Expected: 0xA1 plus 4 bytes, then grant moves to 0, then req 1 resumes with bytes 5 and 6.
- Backpressure: tx_ready held low 10 cycles in HDR and in DATA. Expected: tx_data stable, no beat counted, req_ready[g]=0 throughout the stall.
- HDR_EN=0: req 3 sends 0x5A (last). Expected: tx_data=0x5A one cycle after the request, and no header byte.
- Reset mid-burst: assert rst after the 2nd data byte. Expected: tx_valid=0 and grant_id=0 immediately; the next request is granted starting from requester 0.
